// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, ALU/mux select codes and FSM state enum for the multicycle MIPS core
// Optional BNE decode is controlled by MCCTRL_BNE_EN.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_AND   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;
  localparam logic [2:0] ALU_SUB   = 3'b100;
  localparam logic [2:0] ALU_FUNCT = 3'b111;

  localparam logic [2:0] SRCB_B        = 3'b000;
  localparam logic [2:0] SRCB_FOUR     = 3'b001;
  localparam logic [2:0] SRCB_SIMM     = 3'b010;
  localparam logic [2:0] SRCB_SIMM_SH2 = 3'b011;
  localparam logic [2:0] SRCB_ZIMM     = 3'b100;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

`ifdef MCCTRL_BNE_EN
  localparam logic BNE_EN = 1'b1;
`else
  localparam logic BNE_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_ALUWB  = 4'd7,
    S_EXEC_I = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  typedef struct packed {
    logic       memreq;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       bne;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [2:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: op_legal = 1'b1;
      OP_BNE:                            op_legal = BNE_EN;
      default:                           op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// rtl/mc_outdec.sv - combinational map from (state, op, memready) to datapath control outputs
// BNE handling depends on MCCTRL_BNE_EN via mips_pkg.
module mc_outdec
  import mips_pkg::*;
#(
  parameter int ZEXT_LOGIC = 1
) (
  input  state_t     state,
  input  logic [5:0] op,
  input  logic       memready,
  output ctrl_t      ctrl
);

  localparam logic [2:0] LOGIC_SRCB = (ZEXT_LOGIC != 0) ? SRCB_ZIMM : SRCB_SIMM;

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memreq  = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALU_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.irwrite = memready;
        ctrl.pcwrite = memready;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode decodes.
        ctrl.alusrcb = SRCB_SIMM_SH2;
        ctrl.aluop   = ALU_ADD;
        ctrl.illegal = !op_legal(op);
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_SIMM;
      end
      S_MEMRD: begin
        ctrl.memreq = 1'b1;
        ctrl.iord   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.memreq   = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_FUNCT;
      end
      S_EXEC_I: begin
        ctrl.alusrca = 1'b1;
        case (op)
          OP_ADDI: begin ctrl.aluop = ALU_ADD; ctrl.alusrcb = SRCB_SIMM;  end
          OP_ANDI: begin ctrl.aluop = ALU_AND; ctrl.alusrcb = LOGIC_SRCB; end
          OP_ORI:  begin ctrl.aluop = ALU_OR;  ctrl.alusrcb = LOGIC_SRCB; end
          OP_SLTI: begin ctrl.aluop = ALU_SLT; ctrl.alusrcb = SRCB_SIMM;  end
          default: ;
        endcase
      end
      S_ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = (op == OP_RTYPE);
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_SUB;
        ctrl.branch  = 1'b1;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.bne     = BNE_EN && (op == OP_BNE);
      end
      S_JUMP: begin
        ctrl.pcwrite = 1'b1;
        ctrl.pcsrc   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control FSM: state register, next-state logic, reset gating
// Define MCCTRL_BNE_EN to decode BNE; otherwise BNE is reported as illegal.
module mc_controller
  import mips_pkg::*;
#(
  parameter int ZEXT_LOGIC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       memreq,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic       bne,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [2:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl_raw, ctrl_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = memready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                        state_d = S_MEMADR;
          OP_RTYPE:                            state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:   state_d = S_EXEC_I;
          OP_BEQ:                              state_d = S_BRANCH;
`ifdef MCCTRL_BNE_EN
          OP_BNE:                              state_d = S_BRANCH;
`endif
          OP_J:                                state_d = S_JUMP;
          default:                             state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:  state_d = memready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = memready ? S_FETCH : S_MEMWR;
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_outdec #(
    .ZEXT_LOGIC (ZEXT_LOGIC)
  ) u_outdec (
    .state    (state_q),
    .op       (op),
    .memready (memready),
    .ctrl     (ctrl_raw)
  );

  // Gating on reset itself lets an aborted write drop its strobe without waiting for a clock.
  assign ctrl_out = reset ? ctrl_raw : '0;

  assign memreq   = ctrl_out.memreq;
  assign memwrite = ctrl_out.memwrite;
  assign iord     = ctrl_out.iord;
  assign irwrite  = ctrl_out.irwrite;
  assign pcwrite  = ctrl_out.pcwrite;
  assign branch   = ctrl_out.branch;
  assign bne      = ctrl_out.bne;
  assign regwrite = ctrl_out.regwrite;
  assign regdst   = ctrl_out.regdst;
  assign memtoreg = ctrl_out.memtoreg;
  assign alusrca  = ctrl_out.alusrca;
  assign alusrcb  = ctrl_out.alusrcb;
  assign pcsrc    = ctrl_out.pcsrc;
  assign aluop    = ctrl_out.aluop;
  assign illegal  = ctrl_out.illegal;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - instruction-level model and per-cycle checks for mc_controller
// Expectations for BNE follow MCCTRL_BNE_EN.
module tb_mc_controller;
  import mips_pkg::*;

  localparam int ZEXT = 1;
`ifdef MCCTRL_BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  localparam logic [5:0] T_RTYPE = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_BNE = 6'b000101, T_J = 6'b000010;
  localparam logic [5:0] T_ADDI = 6'b001000, T_ANDI = 6'b001100, T_ORI = 6'b001101;
  localparam logic [5:0] T_SLTI = 6'b001010, T_BAD = 6'b111000;

  logic       clk = 1'b0, reset, memready;
  logic [5:0] op;
  logic       memreq, memwrite, iord, irwrite, pcwrite, branch, bne, regwrite;
  logic       regdst, memtoreg, alusrca, illegal;
  logic [2:0] alusrcb, aluop;
  logic [1:0] pcsrc;
  logic [3:0] state;
  logic [23:0] act;

  int n_checks = 0;
  int n_err = 0;
  int cnt_cyc, cnt_mw, cnt_irw, cnt_lwwb, cnt_ill;

  typedef struct {
    state_t st;
    logic   mr;
  } step_t;
  step_t seq[$];

  mc_controller #(.ZEXT_LOGIC(ZEXT)) dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .memreq(memreq), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcwrite(pcwrite), .branch(branch), .bne(bne), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  assign act = {memreq, memwrite, iord, irwrite, pcwrite, branch, bne, regwrite,
                regdst, memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal, state};

  // Spec table: every output of one state, all unlisted outputs zero.
  function automatic logic [23:0] exp_out(input state_t st, input logic [5:0] o, input logic mr);
    logic mq = 0, mw = 0, io = 0, ir = 0, pw = 0, br = 0, bn = 0, rw = 0;
    logic rd = 0, mt = 0, sa = 0, il = 0;
    logic [2:0] sb = 3'b000, ao = 3'b000;
    logic [1:0] ps = 2'b00;
    logic legal;
    legal = (o inside {T_RTYPE, T_LW, T_SW, T_BEQ, T_J, T_ADDI, T_ANDI, T_ORI, T_SLTI})
            || (BNE_ON && o == T_BNE);
    case (st)
      S_FETCH:  begin mq = 1; sb = 3'b001; ir = mr; pw = mr; end
      S_DECODE: begin sb = 3'b011; il = !legal; end
      S_MEMADR: begin sa = 1; sb = 3'b010; end
      S_MEMRD:  begin mq = 1; io = 1; end
      S_MEMWB:  begin rw = 1; mt = 1; end
      S_MEMWR:  begin mq = 1; mw = 1; io = 1; end
      S_EXEC_R: begin sa = 1; ao = 3'b111; end
      S_EXEC_I: begin
        sa = 1;
        if (o == T_ADDI)      begin ao = 3'b000; sb = 3'b010; end
        else if (o == T_ANDI) begin ao = 3'b001; sb = ZEXT ? 3'b100 : 3'b010; end
        else if (o == T_ORI)  begin ao = 3'b010; sb = ZEXT ? 3'b100 : 3'b010; end
        else if (o == T_SLTI) begin ao = 3'b011; sb = 3'b010; end
      end
      S_ALUWB:  begin rw = 1; rd = (o == T_RTYPE); end
      S_BRANCH: begin sa = 1; ao = 3'b100; br = 1; ps = 2'b01; bn = (o == T_BNE); end
      S_JUMP:   begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {mq, mw, io, ir, pw, br, bn, rw, rd, mt, sa, sb, ps, ao, il, 4'(st)};
  endfunction

  task automatic check(input string nm, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Builds the state path of one instruction, then drives and checks it cycle by cycle.
  // Entered just after a falling edge; abort_at >= 0 asserts reset during that step.
  task automatic run_instr(input logic [5:0] opc, input int fw, input int mw,
                           input string nm, input int abort_at);
    seq.delete();
    for (int k = 0; k < fw; k++) seq.push_back('{S_FETCH, 1'b0});
    seq.push_back('{S_FETCH, 1'b1});
    seq.push_back('{S_DECODE, 1'b1});
    case (opc)
      T_LW: begin
        seq.push_back('{S_MEMADR, 1'b1});
        for (int k = 0; k < mw; k++) seq.push_back('{S_MEMRD, 1'b0});
        seq.push_back('{S_MEMRD, 1'b1});
        seq.push_back('{S_MEMWB, 1'b0});
      end
      T_SW: begin
        seq.push_back('{S_MEMADR, 1'b0});
        for (int k = 0; k < mw; k++) seq.push_back('{S_MEMWR, 1'b0});
        seq.push_back('{S_MEMWR, 1'b1});
      end
      T_RTYPE: begin
        seq.push_back('{S_EXEC_R, 1'b0});
        seq.push_back('{S_ALUWB, 1'b1});
      end
      T_ADDI, T_ANDI, T_ORI, T_SLTI: begin
        seq.push_back('{S_EXEC_I, 1'b1});
        seq.push_back('{S_ALUWB, 1'b0});
      end
      T_BEQ: seq.push_back('{S_BRANCH, 1'b0});
      T_BNE: if (BNE_ON) seq.push_back('{S_BRANCH, 1'b1});
      T_J:   seq.push_back('{S_JUMP, 1'b0});
      default: ;
    endcase
    cnt_cyc = seq.size(); cnt_mw = 0; cnt_irw = 0; cnt_lwwb = 0; cnt_ill = 0;
    for (int i = 0; i < seq.size(); i++) begin
      memready = seq[i].mr;
      op = (seq[i].st == S_FETCH) ? 6'h3f : opc;
      #1;
      check($sformatf("%s_step%0d", nm, i), act, exp_out(seq[i].st, op, seq[i].mr));
      cnt_mw   += int'(memwrite);
      cnt_irw  += int'(irwrite);
      cnt_lwwb += int'(regwrite && memtoreg);
      cnt_ill  += int'(illegal);
      if (i == abort_at) begin
        #2 reset = 1'b0;
        #1;
        check($sformatf("%s_abort_outputs", nm), act, 24'h0);
        check_int($sformatf("%s_abort_memwrite", nm), int'(memwrite), 0);
        @(negedge clk);
        check_int($sformatf("%s_abort_state", nm), int'(state), 0);
        reset = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] e;
    reset = 1'b0; op = T_LW; memready = 1'b1;
    @(negedge clk); #1;
    check("reset_outputs", act, 24'h0);
    @(negedge clk); #1;
    check("reset_hold", act, 24'h0);
    check_int("reset_state", int'(state), 0);

    // Model pins: hand-computed literal rows.
    e = exp_out(S_FETCH, 6'h00, 1'b1);
    check("model_fetch_ready", e, 24'b1_0_0_1_1_0_0_0_0_0_0_001_00_000_0_0000);
    e = exp_out(S_EXEC_I, T_ANDI, 1'b0);
    check("model_andi_exec", e, 24'b0_0_0_0_0_0_0_0_0_0_1_100_00_001_0_1000);
    e = exp_out(S_BRANCH, T_BEQ, 1'b0);
    check("model_beq", e, 24'b0_0_0_0_0_1_0_0_0_0_1_000_01_100_0_1001);

    @(negedge clk);
    reset = 1'b1;
    run_instr(T_LW, 0, 0, "lw", -1);
    check_int("lw_cycles", cnt_cyc, 5);
    check_int("lw_memwb_writes", cnt_lwwb, 1);

    run_instr(T_SW, 0, 3, "sw_wait", -1);
    check_int("sw_memwrite_cycles", cnt_mw, 4);
    check_int("sw_cycles", cnt_cyc, 7);

    run_instr(T_RTYPE, 2, 0, "rtype_fwait", -1);
    check_int("fetch_irwrite_pulses", cnt_irw, 1);
    check_int("rtype_cycles", cnt_cyc, 6);

    run_instr(T_BEQ, 0, 0, "beq", -1);
    check_int("beq_cycles", cnt_cyc, 3);
    run_instr(T_BNE, 0, 0, "bne", -1);
    check_int("bne_cycles", cnt_cyc, BNE_ON ? 3 : 2);
    check_int("bne_illegal", cnt_ill, BNE_ON ? 0 : 1);

    run_instr(T_ANDI, 0, 0, "andi", -1);
    run_instr(T_ADDI, 0, 0, "addi", -1);
    run_instr(T_ORI, 1, 0, "ori", -1);
    run_instr(T_SLTI, 0, 0, "slti", -1);
    check_int("itype_cycles", cnt_cyc, 4);
    run_instr(T_J, 0, 0, "jump", -1);
    check_int("jump_cycles", cnt_cyc, 3);
    run_instr(T_LW, 1, 2, "lw_wait", -1);
    check_int("lw_wait_cycles", cnt_cyc, 8);

    run_instr(T_BAD, 0, 0, "illegal", -1);
    check_int("illegal_cycles", cnt_cyc, 2);
    check_int("illegal_pulses", cnt_ill, 1);

    run_instr(T_SW, 0, 5, "sw_abort", 4);
    run_instr(T_ADDI, 0, 0, "after_abort", -1);

    #1;
    check_int("final_state", int'(state), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control FSM for the MIPS core. It sequences a shared-memory datapath: one ALU, one memory port and one register file are reused across 3–5 states per instruction. It decodes `op` from the instruction register and drives per-state datapath enables and mux selects. It stalls on a memory ready handshake. It sits beside the multicycle datapath and replaces the single-cycle main decoder; the existing ALU decoder still consumes `aluop`.

## Interface
Parameters:
- `ZEXT_LOGIC`, default 1: if 1, ANDI/ORI use the zero-extended immediate (`alusrcb`=100); if 0, they use the sign-extended immediate (`alusrcb`=010).

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low; 0 forces the FSM to FETCH immediately.
- `op`, in, 6: opcode from the instruction register.
- `memready`, in, 1: memory completes the current access this cycle.
- `memreq`, out, 1: memory access requested.
- `memwrite`, out, 1: memory write strobe.
- `iord`, out, 1: memory address select; 0 = PC, 1 = ALUOut.
- `irwrite`, out, 1: load the instruction register.
- `pcwrite`, out, 1: unconditional PC load.
- `branch`, out, 1: conditional PC load if zero.
- `bne`, out, 1: invert the zero condition.
- `regwrite`, out, 1: register file write enable.
- `regdst`, out, 1: 1 = rd, 0 = rt.
- `memtoreg`, out, 1: 1 = data register, 0 = ALUOut.
- `alusrca`, out, 1: 0 = PC, 1 = A.
- `alusrcb`, out, 3: 000 = B, 001 = const 4, 010 = signimm, 011 = signimm<<2, 100 = zeroimm.
- `pcsrc`, out, 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- `aluop`, out, 3: 000 add, 001 and, 010 or, 011 slt, 100 sub, 111 funct.
- `illegal`, out, 1: single-cycle pulse on an unsupported opcode.
- `state`, out, 4: current state encoding, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, ALUWB, EXEC_I, BRANCH, JUMP.
- FETCH:
  - Outputs: `memreq`=1, `iord`=0, `alusrca`=0, `alusrcb`=001, `aluop`=add, `pcsrc`=00.
  - `irwrite` and `pcwrite` are asserted only in a cycle where `memready`=1.
  - Next state: DECODE when `memready`=1, else hold FETCH.
- DECODE:
  - Outputs: `alusrca`=0, `alusrcb`=011, `aluop`=add (branch target into ALUOut).
  - LW/SW → MEMADR. RTYPE → EXEC_R. ADDI/ANDI/ORI/SLTI → EXEC_I. BEQ/BNE → BRANCH. J → JUMP.
  - Any other opcode: `illegal`=1, next state FETCH.
- MEMADR: `alusrca`=1, `alusrcb`=010, add. LW → MEMRD; SW → MEMWR.
- MEMRD: `memreq`=1, `iord`=1. Holds until `memready`, then → MEMWB.
- MEMWB: `regwrite`=1, `regdst`=0, `memtoreg`=1. → FETCH.
- MEMWR: `memreq`=1, `memwrite`=1, `iord`=1. Outputs held stable until `memready`, then → FETCH.
- EXEC_R: `alusrca`=1, `alusrcb`=000, `aluop`=111. → ALUWB.
- EXEC_I: `alusrca`=1, `aluop` = ADDI 000, ANDI 001, ORI 010, SLTI 011.
  - `alusrcb` = 010 for ADDI and SLTI.
  - `alusrcb` for ANDI/ORI follows `ZEXT_LOGIC`.
  - → ALUWB.
- ALUWB: `regwrite`=1, `memtoreg`=0, `regdst` = 1 if the instruction is RTYPE, else 0. → FETCH.
- BRANCH: `alusrca`=1, `alusrcb`=000, sub, `branch`=1, `pcsrc`=01. `bne`=1 for BNE only. → FETCH.
- JUMP: `pcwrite`=1, `pcsrc`=10. → FETCH.
- Every output not listed for a state is 0.
- `op` is sampled each cycle and is valid from DECODE until return to FETCH; the IR is stable then.

## Timing
- State register is the only storage. Outputs decode combinationally from state; `op` and `memready` are used where listed.
- Cycles with zero wait: BRANCH/J 3, R/I-type 4, SW 4, LW 5. Each wait cycle on `memready` adds one.
- Reset:
  - While `reset`=0: state is FETCH, `state`=0, and all outputs are forced to 0, including `memreq`.
  - On release, the first FETCH request starts in that same cycle.
- Reset mid-access (MEMWR waiting): `memwrite` drops asynchronously, and no partial register or PC update follows.
- `memready` is ignored outside FETCH/MEMRD/MEMWR.
- `illegal` is asserted only in DECODE, one cycle.
- Unreachable state encodings → FETCH.

## Configuration
- `MCCTRL_BNE_EN` defined: BNE (000101) is decoded to BRANCH with `bne`=1.
- `MCCTRL_BNE_EN` undefined: BNE raises `illegal` and returns to FETCH; `bne` is tied to 0.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants (RTYPE, LW, SW, BEQ, BNE, J, ADDI, ANDI, ORI, SLTI);
  - the `aluop` code constants;
  - the `alusrcb` and `pcsrc` select constants;
  - the FSM state enum (4-bit, FETCH = 0).
- One sub-module `mc_outdec`: pure combinational map from (state, op, memready) to the control outputs. The top holds the state register and the next-state logic.

## Test plan
- Reset low, then high with `memready`=1 and LW, then continuous `memready`=1: states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH over 5 cycles; `regwrite`=1 with `memtoreg`=1 only in MEMWB.
- SW with `memready` held low for 3 cycles in MEMWR: `memwrite`=1 for 4 consecutive cycles, then FETCH.
- FETCH with `memready`=0 for 2 cycles: `irwrite` and `pcwrite` stay 0 until the ready cycle, then pulse once.
- BEQ vs BNE with the macro defined: BRANCH asserts `branch`=1, `aluop`=100, `pcsrc`=01, with `bne`=0 and 1 respectively. With the macro undefined, BNE gives `illegal`=1 in DECODE, then FETCH.
- ANDI with `ZEXT_LOGIC`=1: EXEC_I drives `alusrcb`=100, `aluop`=001. Op 6'b111000 gives `illegal`=1 and a 2-cycle return to FETCH.
- `reset` driven low in MEMWR mid-wait: `memwrite` and `memreq` go to 0 immediately; `state`=0.
